// File: rtl/ad_serial_emulator.sv
// Stand-in for an AD7643-style 18-bit serial-slave ADC, fed by an internal pattern generator.
// Define AD_EMU_LFSR_EN to build the LFSR pattern (PAT_SEL=2); otherwise PAT_SEL=2 selects the ramp.
module ad_serial_emulator #(
    parameter int                DATA_W      = 18,
    parameter int                CONV_CYCLES = 80,
    parameter logic [DATA_W-1:0] RAMP_INIT   = '0,
    parameter logic [DATA_W-1:0] RAMP_STEP   = DATA_W'(1),
    parameter logic [DATA_W-1:0] FIXED_CODE  = DATA_W'(18'h2A5A5)
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        ADCS,
    input  logic        ADCNVST,
    input  logic        ADSCLK,
    input  logic [1:0]  PAT_SEL,
    output logic        ADBUSY,
    output logic        ADSYNC,
    output logic        ADSDOUT,
    output logic [15:0] SAMPLE_CNT,
    output logic        OVERRUN
);
    localparam int BUSY_W = 10;
    localparam int BIT_W  = $clog2(DATA_W + 1);
    localparam logic [DATA_W-1:0] ALT_A = DATA_W'(18'h15555);
    localparam logic [DATA_W-1:0] ALT_B = DATA_W'(18'h2AAAA);

    typedef enum logic [1:0] {IDLE, CONV, SHIFT} state_t;

    // Reset asserts asynchronously, releases two clocks later.
    logic [1:0] rst_pipe;
    logic       rst_n;
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) rst_pipe <= 2'b00;
        else       rst_pipe <= {rst_pipe[0], 1'b1};
    end
    assign rst_n = rst_pipe[1];

    // Pin bits: [2]=ADSCLK, [1]=ADCNVST, [0]=ADCS; all idle high.
    logic [2:0] pin_s1, pin_s2, pin_h, fall, rise;
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            pin_s1 <= 3'b111;
            pin_s2 <= 3'b111;
            pin_h  <= 3'b111;
        end else begin
            pin_s1 <= {ADSCLK, ADCNVST, ADCS};
            pin_s2 <= pin_s1;
            pin_h  <= pin_s2;
        end
    end
    assign fall = pin_h & ~pin_s2;
    assign rise = ~pin_h & pin_s2;

    logic selected, cs_rise, cnv_fall, sclk_fall;
    assign selected  = ~pin_s2[0];
    assign cs_rise   = rise[0];
    assign cnv_fall  = fall[1];
    assign sclk_fall = fall[2];

    logic [DATA_W-1:0] ramp, pat_word;
    logic              alt_ph;
`ifdef AD_EMU_LFSR_EN
    logic [17:0]       lfsr;
`endif

    always_comb begin
        pat_word = ramp;
        case (PAT_SEL)
            2'd1: pat_word = FIXED_CODE;
`ifdef AD_EMU_LFSR_EN
            2'd2: pat_word = DATA_W'(lfsr);
`endif
            2'd3: pat_word = alt_ph ? ALT_B : ALT_A;
            default: ;
        endcase
    end

    state_t            state_q, state_d;
    logic [BUSY_W-1:0] busy_q, busy_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic              latch, done, ovr_set;

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        latch   = 1'b0;
        done    = 1'b0;
        ovr_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (cnv_fall && selected) begin
                    state_d = CONV;
                    busy_d  = BUSY_W'(CONV_CYCLES);
                end
            end
            CONV: begin
                if (busy_q <= BUSY_W'(1)) begin
                    latch   = 1'b1;
                    sh_d    = pat_word;
                    bit_d   = BIT_W'(DATA_W);
                    state_d = SHIFT;
                end else begin
                    busy_d = busy_q - 1'b1;
                end
            end
            SHIFT: begin
                // Aborts take priority over a coincident clock fall.
                if (cs_rise) begin
                    ovr_set = 1'b1;
                    state_d = IDLE;
                end else if (cnv_fall) begin
                    ovr_set = 1'b1;
                    state_d = CONV;
                    busy_d  = BUSY_W'(CONV_CYCLES);
                end else if (sclk_fall && selected) begin
                    sh_d  = sh_q << 1;
                    bit_d = bit_q - 1'b1;
                    if (bit_q == BIT_W'(1)) begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            busy_q     <= '0;
            bit_q      <= '0;
            sh_q       <= '0;
            SAMPLE_CNT <= '0;
            OVERRUN    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            if (done)    SAMPLE_CNT <= SAMPLE_CNT + 16'd1;
            if (ovr_set) OVERRUN    <= 1'b1;
        end
    end

    // Every generator steps on every latch so sequences stay predictable across PAT_SEL changes.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            ramp   <= RAMP_INIT;
            alt_ph <= 1'b0;
`ifdef AD_EMU_LFSR_EN
            lfsr   <= 18'h00001;
`endif
        end else if (latch) begin
            ramp   <= ramp + RAMP_STEP;
            alt_ph <= ~alt_ph;
`ifdef AD_EMU_LFSR_EN
            lfsr   <= {lfsr[16:0], lfsr[17] ^ lfsr[10]};
`endif
        end
    end

    assign ADBUSY  = (state_q == CONV);
    assign ADSYNC  = (state_q == SHIFT) && selected;
    assign ADSDOUT = ADSYNC && sh_q[DATA_W-1];
endmodule

// File: tb/tb_ad_serial_emulator.sv
// Directed bench for ad_serial_emulator: table of frames plus abort/deselect/reset sequences.
module tb_ad_serial_emulator;
    logic        CLK = 1'b0;
    logic        RSTN, ADCS, ADCNVST, ADSCLK;
    logic [1:0]  PAT_SEL;
    logic        ADBUSY, ADSYNC, ADSDOUT, OVERRUN;
    logic [15:0] SAMPLE_CNT;

    int n_pass = 0;
    int n_tot  = 0;

    ad_serial_emulator #(
        .DATA_W(18), .CONV_CYCLES(80), .RAMP_INIT(18'h3FFFE),
        .RAMP_STEP(18'h00001), .FIXED_CODE(18'h2A5A5)
    ) dut (
        .CLK(CLK), .RSTN(RSTN), .ADCS(ADCS), .ADCNVST(ADCNVST), .ADSCLK(ADSCLK),
        .PAT_SEL(PAT_SEL), .ADBUSY(ADBUSY), .ADSYNC(ADSYNC), .ADSDOUT(ADSDOUT),
        .SAMPLE_CNT(SAMPLE_CNT), .OVERRUN(OVERRUN)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0]  sel;
        logic [17:0] word;
        logic [15:0] cnt;
    } vec_t;
    vec_t vt [8];

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Pulse CNVST low (optionally SCLK too) and measure the BUSY high time in CLK cycles.
    task automatic conv_busy(input logic with_sclk, output int blen);
        blen    = 0;
        ADCNVST = 1'b0;
        if (with_sclk) ADSCLK = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge CLK);
            if (i == 3) begin
                ADCNVST = 1'b1;
                ADSCLK  = 1'b1;
            end
            if (ADBUSY) blen++;
            else if (blen > 0) break;
        end
    endtask

    // n SCLK periods: sample while high, then fall and rise, 4 CLK per phase.
    task automatic sclk_bits(input int n, output logic [17:0] w);
        w = '0;
        for (int b = 0; b < n; b++) begin
            cyc(4);
            w = {w[16:0], ADSDOUT};
            ADSCLK = 1'b0;
            cyc(4);
            ADSCLK = 1'b1;
        end
    endtask

    task automatic read_frame(input string nm, input logic [17:0] exp_w, input logic [15:0] exp_cnt);
        logic [17:0] w;
        logic        seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (ADSYNC) begin
                seen = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        chk({nm, "_sync_seen"}, 32'(seen), 32'd1);
        sclk_bits(18, w);
        cyc(4);
        chk({nm, "_word"}, 32'(w), 32'(exp_w));
        chk({nm, "_sync_end"}, 32'(ADSYNC), 32'd0);
        chk({nm, "_cnt"}, 32'(SAMPLE_CNT), 32'(exp_cnt));
    endtask

    task automatic do_frame(input string nm, input logic [1:0] sel, input logic [17:0] exp_w,
                            input logic [15:0] exp_cnt);
        int blen;
        PAT_SEL = sel;
        conv_busy(1'b0, blen);
        chk({nm, "_busy_len"}, 32'(blen), 32'd80);
        read_frame(nm, exp_w, exp_cnt);
    endtask

    initial begin
        logic [17:0] w;
        int          blen;

        // Every latch advances all generators; ramp starts at 3FFFE.
        vt[0] = '{2'd0, 18'h3FFFE, 16'd1};
        vt[1] = '{2'd0, 18'h3FFFF, 16'd2};
        vt[2] = '{2'd0, 18'h00000, 16'd3};
        vt[3] = '{2'd3, 18'h2AAAA, 16'd4};
        vt[4] = '{2'd3, 18'h15555, 16'd5};
        vt[5] = '{2'd1, 18'h2A5A5, 16'd6};
`ifdef AD_EMU_LFSR_EN
        vt[6] = '{2'd2, 18'h00040, 16'd7};
`else
        vt[6] = '{2'd2, 18'h00004, 16'd7};
`endif
        vt[7] = '{2'd0, 18'h00005, 16'd8};

        RSTN = 1'b0; ADCS = 1'b1; ADCNVST = 1'b1; ADSCLK = 1'b1; PAT_SEL = 2'd0;
        cyc(3);
        chk("rst_busy", 32'(ADBUSY), 0);
        chk("rst_sync", 32'(ADSYNC), 0);
        chk("rst_sdout", 32'(ADSDOUT), 0);
        chk("rst_cnt", 32'(SAMPLE_CNT), 0);
        chk("rst_ovr", 32'(OVERRUN), 0);
        RSTN = 1'b1;
        cyc(4);
        ADCS = 1'b0;
        cyc(4);

        for (int i = 0; i < 8; i++)
            do_frame($sformatf("tbl%0d", i), vt[i].sel, vt[i].word, vt[i].cnt);
        chk("tbl_ovr", 32'(OVERRUN), 0);

        // Deselect during conversion: outputs gated until ADCS returns, then normal frame.
        PAT_SEL = 2'd0;
        ADCNVST = 1'b0; cyc(4); ADCNVST = 1'b1;
        cyc(20);
        ADCS = 1'b1;
        cyc(100);
        chk("desel_busy", 32'(ADBUSY), 0);
        chk("desel_sync", 32'(ADSYNC), 0);
        chk("desel_sdout", 32'(ADSDOUT), 0);
        ADCS = 1'b0;
        read_frame("desel", 18'h00006, 16'd9);
        chk("desel_ovr", 32'(OVERRUN), 0);

        // CNVST abort coinciding with an SCLK fall after 5 bits.
        conv_busy(1'b0, blen);
        sclk_bits(5, w);
        cyc(4);
        conv_busy(1'b1, blen);
        chk("abort_busy_len", 32'(blen), 32'd80);
        chk("abort_ovr", 32'(OVERRUN), 1);
        chk("abort_cnt", 32'(SAMPLE_CNT), 32'd9);
        read_frame("abort_next", 18'h00008, 16'd10);

        // Reset mid-SHIFT on the constant pattern, MSB-first bit 2 is a 1.
        PAT_SEL = 2'd1;
        conv_busy(1'b0, blen);
        sclk_bits(2, w);
        cyc(3);
        chk("pre_rst_sdout", 32'(ADSDOUT), 1);
        RSTN = 1'b0;
        #1;
        chk("mid_rst_sync", 32'(ADSYNC), 0);
        chk("mid_rst_sdout", 32'(ADSDOUT), 0);
        chk("mid_rst_cnt", 32'(SAMPLE_CNT), 0);
        chk("mid_rst_ovr", 32'(OVERRUN), 0);
        cyc(3);
        RSTN = 1'b1;
        cyc(6);
        do_frame("post_rst", 2'd0, 18'h3FFFE, 16'd1);

        // ADCS rise during SHIFT aborts to IDLE.
        conv_busy(1'b0, blen);
        sclk_bits(3, w);
        ADCS = 1'b1;
        cyc(5);
        chk("csab_ovr", 32'(OVERRUN), 1);
        chk("csab_sync", 32'(ADSYNC), 0);
        chk("csab_busy", 32'(ADBUSY), 0);
        chk("csab_cnt", 32'(SAMPLE_CNT), 32'd1);
        ADCS = 1'b0;
        cyc(5);
        do_frame("csab_next", 2'd0, 18'h00000, 16'd2);

`ifdef AD_EMU_LFSR_EN
        RSTN = 1'b0; cyc(3); RSTN = 1'b1; cyc(6);
        do_frame("lfsr0", 2'd2, 18'h00001, 16'd1);
        do_frame("lfsr1", 2'd2, 18'h00002, 16'd2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
